// File: rtl/ama_riscv_imm_enc_pkg.sv
// Shared types and helpers for the immediate encoder.
// Format codes match the immediate generator's select encoding.
package ama_riscv_imm_enc_pkg;

  localparam logic [3:0] IG_I_TYPE = 4'd1;
  localparam logic [3:0] IG_S_TYPE = 4'd2;
  localparam logic [3:0] IG_B_TYPE = 4'd3;
  localparam logic [3:0] IG_J_TYPE = 4'd4;
  localparam logic [3:0] IG_U_TYPE = 4'd5;

  localparam int IE_ERR_RANGE = 0;
  localparam int IE_ERR_ALIGN = 1;
  localparam int IE_ERR_SEL   = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [3:0]  sel;
    logic [2:0]  err;
  } s1_t;

  function automatic logic [31:0] imm_pack(
    input logic [3:0]  sel,
    input logic [31:0] inst,
    input logic [31:0] imm
  );
    logic [31:0] r;
    r = inst;
    unique case (1'b1)
      (sel == IG_I_TYPE): begin
        r[31:20] = imm[11:0];
      end
      (sel == IG_S_TYPE): begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      (sel == IG_B_TYPE): begin
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
      end
      (sel == IG_J_TYPE): begin
        r[31]    = imm[20];
        r[30:21] = imm[10:1];
        r[20]    = imm[11];
        r[19:12] = imm[19:12];
      end
      (sel == IG_U_TYPE): begin
        r[31:12] = imm[31:12];
      end
      default: begin
        r = inst;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ama_riscv_imm_chk.sv
// Range/alignment/select checker for immediate encoding.
// Purely combinational so the loader can reuse it standalone.
import ama_riscv_imm_enc_pkg::*;

module ama_riscv_imm_chk (
  input  logic [3:0]  sel,
  input  logic [31:0] imm,
  output logic [2:0]  err
);

  logic fit11;
  logic fit12;
  logic fit20;

  assign fit11 = (&imm[31:11]) || (~|imm[31:11]);
  assign fit12 = (&imm[31:12]) || (~|imm[31:12]);
  assign fit20 = (&imm[31:20]) || (~|imm[31:20]);

  always_comb begin
    err = '0;
    unique case (1'b1)
      (sel == IG_I_TYPE),
      (sel == IG_S_TYPE): begin
        err[IE_ERR_RANGE] = !fit11;
      end
      (sel == IG_B_TYPE): begin
        err[IE_ERR_RANGE] = !fit12;
        err[IE_ERR_ALIGN] = imm[0];
      end
      (sel == IG_J_TYPE): begin
        err[IE_ERR_RANGE] = !fit20;
        err[IE_ERR_ALIGN] = imm[0];
      end
      (sel == IG_U_TYPE): begin
        err[IE_ERR_ALIGN] = |imm[11:0];
      end
      default: begin
        err[IE_ERR_SEL] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ama_riscv_imm_enc.sv
// Two-stage valid/ready immediate encoder: check, then pack.
// Errored items pass the template through untouched.
import ama_riscv_imm_enc_pkg::*;

module ama_riscv_imm_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [2:0]       out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_advance;
  logic        out_fire;
  logic [2:0]  chk_err;
  logic [31:0] pack_inst;
  s1_t         s1;

  ama_riscv_imm_chk u_chk (
    .sel (in_sel),
    .imm (in_imm),
    .err (chk_err)
  );

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;
  assign out_fire   = s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.inst <= in_inst;
        s1.imm  <= in_imm;
        s1.sel  <= in_sel;
        s1.err  <= chk_err;
      end
    end
  end

  always_comb begin
    pack_inst = s1.inst;
    if (s1.err == 3'b000) begin
      pack_inst = imm_pack(s1.sel, s1.inst, s1.imm);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_inst <= '0;
      out_err  <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= pack_inst;
        out_err  <= s1.err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_fire && (out_err != 3'b000)
                 && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_imm_enc.sv
// Scoreboard bench for ama_riscv_imm_enc with directed vectors.
import ama_riscv_imm_enc_pkg::*;

module tb_ama_riscv_imm_enc;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_sel = '0;
  logic [31:0]      in_inst = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_inst;
  logic [2:0]       out_err;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  ama_riscv_imm_enc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_inst   (in_inst),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  err;
    logic [3:0]  sel;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [34:0] act,
                     input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imm_gen(input logic [3:0] sel,
                                          input logic [31:0] i);
    logic [31:0] r;
    r = '0;
    case (sel)
      IG_I_TYPE: r = {{20{i[31]}}, i[31:20]};
      IG_S_TYPE: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IG_B_TYPE: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IG_J_TYPE: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IG_U_TYPE: r = {i[31:12], 12'h000};
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Monitor: pops on each output transfer and checks stall stability.
  initial begin
    exp_t        e;
    logic        held;
    logic [34:0] hv;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held && out_valid)
          chk("stall_hold", {out_err, out_inst}, hv);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", {out_err, out_inst}, 35'h7_FFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("out_inst", {3'b000, out_inst}, {3'b000, e.inst});
            chk("out_err", {32'h0, out_err}, {32'h0, e.err});
            if (e.err == 3'b000 && e.sel != IG_U_TYPE && e.sel != 4'h0)
              chk("round_trip", {3'b000, imm_gen(e.sel, out_inst)},
                  {3'b000, e.imm});
          end
        end
        held = out_valid && !out_ready;
        hv = {out_err, out_inst};
      end
    end
  end

  task automatic push(input logic [3:0] s, input logic [31:0] ei,
                      input logic [2:0] ee, input logic [31:0] im);
    exp_t e;
    e.inst = ei;
    e.err = ee;
    e.sel = s;
    e.imm = im;
    q.push_back(e);
  endtask

  task automatic send(input logic [3:0] s, input logic [31:0] t,
                      input logic [31:0] im, input logic [31:0] ei,
                      input logic [2:0] ee);
    in_valid = 1'b1;
    in_sel = s;
    in_inst = t;
    in_imm = im;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push(s, ei, ee, im);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 35'd0, 35'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 35'(q.size()), 35'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_lat(input logic [3:0] s, input logic [31:0] t,
                          input logic [31:0] im, input logic [31:0] ei,
                          input logic [2:0] ee);
    in_valid = 1'b1;
    in_sel = s;
    in_inst = t;
    in_imm = im;
    @(negedge clk);
    chk("lat_in_ready", {34'h0, in_ready}, 35'd1);
    push(s, ei, ee, im);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_cycle1", {34'h0, out_valid}, 35'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", {34'h0, out_valid}, 35'd1);
  endtask

  logic [31:0] bp_imm[4];
  int          idx;
  int          acc_before;

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout want completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #12;
    chk("reset_out_valid", {34'h0, out_valid}, 35'd0);
    chk("reset_out", {out_err, out_inst}, 35'd0);
    chk("reset_err_cnt", {19'h0, err_cnt}, 35'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_lat(IG_I_TYPE, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 3'b000);
    send(IG_S_TYPE, 32'h0000_2023, 32'h0000_07FC, 32'h7E00_2E23, 3'b000);
    send(IG_B_TYPE, 32'h0000_0063, 32'hFFFF_FFFE, 32'hFE00_0FE3, 3'b000);
    drain();
    chk("cnt_after_good", {19'h0, err_cnt}, 35'd0);

    send(IG_B_TYPE, 32'h0000_0063, 32'h0000_0003, 32'h0000_0063, 3'b010);
    drain();
    chk("cnt_b_align", {19'h0, err_cnt}, 35'd1);
    send(IG_J_TYPE, 32'h0000_006F, 32'h0010_0000, 32'h0000_006F, 3'b001);
    drain();
    chk("cnt_j_range", {19'h0, err_cnt}, 35'd2);
    send(4'hF, 32'h0000_0013, 32'h0000_0005, 32'h0000_0013, 3'b100);
    send(IG_U_TYPE, 32'h0000_0037, 32'h1234_5001, 32'h0000_0037, 3'b010);
    send(IG_U_TYPE, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 3'b000);
    send(IG_J_TYPE, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 3'b000);
    send(IG_I_TYPE, 32'h0000_0013, 32'h0000_0800, 32'h0000_0013, 3'b001);
    drain();
    chk("cnt_after_errs", {19'h0, err_cnt}, 35'd5);

    // Backpressure: four offers while the sink stalls for five cycles.
    bp_imm[0] = 32'd1;
    bp_imm[1] = 32'd2;
    bp_imm[2] = 32'd3;
    bp_imm[3] = 32'd4;
    idx = 0;
    acc_before = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (idx < 4);
      in_sel = IG_I_TYPE;
      in_inst = 32'h0000_0013;
      in_imm = (idx < 4) ? bp_imm[idx] : 32'h0;
      @(negedge clk);
      if (cyc < 5)
        chk("bp_in_ready", {34'h0, in_ready}, {34'h0, (cyc < 2)});
      if (cyc >= 5 && cyc <= 8)
        chk("bp_no_gap", {34'h0, out_valid}, 35'd1);
      if (in_valid && in_ready) begin
        push(IG_I_TYPE, {bp_imm[idx][11:0], 20'h00013}, 3'b000, bp_imm[idx]);
        idx++;
      end
      if (cyc == 4) acc_before = idx;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", 35'(acc_before), 35'd2);
    chk("bp_all_in", 35'(idx), 35'd4);
    drain();

    // Saturation: 2^CNT_W + 3 errored transfers.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int n = 0; n < (1 << CNT_W) + 3; n++)
      send(4'hF, 32'h0000_0013, 32'h0, 32'h0000_0013, 3'b100);
    drain();
    chk("cnt_saturate", {19'h0, err_cnt}, {19'h0, 16'hFFFF});

    // Reset with both stages full.
    out_ready = 1'b0;
    send(4'hF, 32'h0000_0013, 32'h0, 32'h0000_0013, 3'b100);
    send(IG_I_TYPE, 32'h0000_0013, 32'h7, 32'h0070_0013, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {34'h0, out_valid}, 35'd0);
    chk("rst_err_cnt", {19'h0, err_cnt}, 35'd0);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_lat(IG_I_TYPE, 32'h0000_0093, 32'h0000_0123, 32'h1230_0093, 3'b000);
    drain();

    // Clear coincident with an errored transfer.
    send(IG_B_TYPE, 32'h0000_0063, 32'h0000_1001, 32'h0000_0063, 3'b011);
    drain();
    chk("cnt_one", {19'h0, err_cnt}, 35'd1);
    send(IG_B_TYPE, 32'h0000_0063, 32'h0000_0001, 32'h0000_0063, 3'b010);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_prio", {19'h0, err_cnt}, 35'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
